fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and decoder.
- Holds the program counter and issues word requests to instruction memory through a request/response handshake.
- Registers the returned instruction with its PC into the fetch/decode register, whose `ins` output drives the immediate generator's `ins` input.
- Computes branch, jal and jalr redirect targets from a base plus the generated immediate, and squashes any in-flight fetch on redirect.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, imem handshake, fetch/decode register and redirect
// Optional feature macro: MISALIGN_TRAP_EN (adds misalign_trap port and S_TRAP state).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic        redirect_sel,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
`ifdef MISALIGN_TRAP_EN
  localparam logic [2:0] S_TRAP = 3'd4;
`endif

  logic [2:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;
  logic        skid_valid;

  logic        slot_free;
  logic        accept;
  logic        outstanding;
  logic [31:0] target_sum;
  logic [31:0] target;

  assign slot_free  = !(ins_valid && stall);
  assign imem_req   = !rst && (state == S_REQ) && slot_free && !skid_valid;
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req && imem_ready;
  assign target_sum = redirect_base + redirect_imm;

  // A request is still owed a response after this edge: it must be drained in S_DROP.
  assign outstanding = ((state == S_REQ) && accept) ||
                       (((state == S_WAIT) || (state == S_DROP)) && !imem_rvalid);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign target     = target_sum & ~{31'b0, redirect_sel};
  assign misaligned = (target[1:0] != 2'b00);
`else
  assign target     = target_sum & ~{31'b0, redirect_sel} & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      pend_pc    <= RESET_PC;
      ins        <= NOP_INS;
      ins_pc     <= RESET_PC;
      ins_valid  <= 1'b0;
      skid_data  <= NOP_INS;
      skid_pc    <= RESET_PC;
      skid_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else if (redirect_en) begin
      fetch_pc   <= target;
      ins        <= NOP_INS;
      ins_valid  <= 1'b0;
      skid_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= misaligned;
      state <= outstanding ? S_DROP : (misaligned ? S_TRAP : S_REQ);
`else
      state <= outstanding ? S_DROP : S_REQ;
`endif
    end else begin
      // Consumption; a load in the case below overrides this.
      if (ins_valid && !stall) begin
        ins_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (accept) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              ins       <= imem_rdata;
              ins_pc    <= pend_pc;
              ins_valid <= 1'b1;
              state     <= S_REQ;
            end else begin
              skid_data  <= imem_rdata;
              skid_pc    <= pend_pc;
              skid_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ins        <= skid_data;
            ins_pc     <= skid_pc;
            ins_valid  <= 1'b1;
            skid_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
`ifdef MISALIGN_TRAP_EN
            state <= misalign_trap ? S_TRAP : S_REQ;
`else
            state <= S_REQ;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        S_TRAP: begin
          state <= S_TRAP;
        end
`endif
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (table vectors plus scoreboard)
// Optional feature macro: MISALIGN_TRAP_EN.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_en;
  logic        redirect_sel;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_sel(redirect_sel),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] target;
    int          lat;
    int          gap;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_paddr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic void add_vec(input logic s, input logic [31:0] b, input logic [31:0] i,
                                  input logic [31:0] t, input int l, input int g);
    vec_t v;
    v.sel = s; v.base = b; v.imm = i; v.target = t; v.lat = l; v.gap = g;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping on pre-edge values, then memory model update at negedge.
  task automatic tick();
    logic        acc;
    logic        redir;
    logic [31:0] aaddr;
    sb_t         e;
    #1;
    acc   = imem_req && imem_ready;
    aaddr = imem_addr;
    redir = redirect_en;
    if (ins_valid && !redir) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: ins_valid with ins_pc %h ins %h, expected no entry", ins_pc, ins);
      end else begin
        e = sb[0];
        check("sb_ins_pc", ins_pc, e.pc);
        check("sb_ins", ins, e.data);
        if (!stall) void'(sb.pop_front());
      end
    end
    if (acc) begin
      e.pc = aaddr;
      e.data = mem_word(aaddr);
      sb.push_back(e);
    end
    if (redir) sb.delete();
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_cnt = mem_lat;
      mem_paddr = aaddr;
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_pend = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(mem_paddr);
      end
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    #1;
    for (int k = 0; k < budget; k++) begin
      if (imem_req) return;
      tick();
    end
    if (!imem_req) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: imem_req got 0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  task automatic do_redirect(input logic s, input logic [31:0] b, input logic [31:0] i);
    redirect_en = 1'b1;
    redirect_sel = s;
    redirect_base = b;
    redirect_imm = i;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_sel = 1'b0;
    redirect_base = 32'h0; redirect_imm = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    add_vec(1'b1, 32'h0000_2001, 32'h0000_0004, 32'h0000_2004, 1, 2);
    add_vec(1'b0, 32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_00F8, 1, 3);
    add_vec(1'b0, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0004, 2, 1);
    add_vec(1'b1, 32'h0000_1003, 32'h0000_0001, 32'h0000_1004, 2, 4);
    add_vec(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 5);
    add_vec(1'b0, 32'h0000_0040, 32'h0000_0020, 32'h0000_0060, 3, 2);
    add_vec(1'b1, 32'h0000_3FF0, 32'h0000_0011, 32'h0000_4000, 1, 0);
`ifndef MISALIGN_TRAP_EN
    add_vec(1'b0, 32'h0000_0103, 32'h0000_0000, 32'h0000_0100, 1, 3);
    add_vec(1'b1, 32'h0000_2003, 32'h0000_0000, 32'h0000_2000, 2, 2);
`endif

    // Reset state and first-fetch latency.
    repeat (2) @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check("rst_ins", ins, NOP);
    check("rst_ins_pc", ins_pc, 32'h0);
    check1("rst_ins_valid", ins_valid, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check1("rst_trap", misalign_trap, 1'b0);
`endif
    rst = 1'b0;
    #1;
    check1("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check1("lat_not_yet_valid", ins_valid, 1'b0);
    check1("wait_no_req", imem_req, 1'b0);
    tick();
    check("first_ins", ins, 32'h0050_0093);
    check("first_ins_pc", ins_pc, 32'h0);
    check1("first_valid", ins_valid, 1'b1);
    check("next_addr", imem_addr, 32'h4);
    check1("next_req", imem_req, 1'b1);

    // Stall while the second response arrives and is held.
    tick();
    stall = 1'b1;
    tick();
    check("stall_ins", ins, 32'h00A0_0113);
    check("stall_ins_pc", ins_pc, 32'h4);
    check1("stall_valid", ins_valid, 1'b1);
    check1("stall_no_req", imem_req, 1'b0);
    repeat (2) begin
      tick();
      check("stall_hold_ins", ins, 32'h00A0_0113);
      check1("stall_hold_valid", ins_valid, 1'b1);
      check1("stall_hold_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    #1;
    check1("unstall_req", imem_req, 1'b1);
    check("unstall_addr", imem_addr, 32'h8);
    tick();
    tick();

    // Redirect while waiting on a slow response: late data must be dropped.
    mem_lat = 3;
    tick();
    do_redirect(1'b0, 32'h0000_0100, 32'hFFFF_FFF8);
    check1("redir_valid", ins_valid, 1'b0);
    check("redir_ins", ins, NOP);
    check("redir_addr", imem_addr, 32'h0000_00F8);
    check1("drop_no_req", imem_req, 1'b0);
    wait_req(10, "drop_wait");
    check("after_drop_addr", imem_addr, 32'h0000_00F8);
    mem_lat = 1;

    // Redirect target table.
    for (int i = 0; i < vecs.size(); i++) begin
      mem_lat = vecs[i].lat;
      repeat (vecs[i].gap) tick();
      do_redirect(vecs[i].sel, vecs[i].base, vecs[i].imm);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].target);
      check1($sformatf("vec%0d_valid", i), ins_valid, 1'b0);
      check($sformatf("vec%0d_ins", i), ins, NOP);
    end
    repeat (4) tick();

    // PC wrap at the top of the address space.
    mem_lat = 1;
    do_redirect(1'b0, 32'hFFFF_FFF0, 32'h0000_000C);
    wait_req(10, "wrap_wait");
    check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_post", imem_addr, 32'h0);
    tick();
    check("wrap_ins_pc", ins_pc, 32'hFFFF_FFFC);
    check1("wrap_valid", ins_valid, 1'b1);

    // Reset with a held, stalled instruction.
    wait_req(10, "rst_prep_wait");
    tick();
    stall = 1'b1;
    tick();
    check1("prerst_valid", ins_valid, 1'b1);
    rst = 1'b1;
    imem_rvalid = 1'b0;
    mem_pend = 1'b0;
    sb.delete();
    #1;
    check("midrst_ins", ins, NOP);
    check1("midrst_valid", ins_valid, 1'b0);
    check1("midrst_req", imem_req, 1'b0);
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b0;
    #1;
    check("postrst_addr", imem_addr, 32'h0);
    check1("postrst_req", imem_req, 1'b1);
    tick();
    tick();
    check("postrst_ins", ins, 32'h0050_0093);
    check("postrst_ins_pc", ins_pc, 32'h0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned jalr traps until an aligned redirect.
    do_redirect(1'b1, 32'h0000_2003, 32'h0);
    check1("trap_set", misalign_trap, 1'b1);
    repeat (6) begin
      tick();
      check1("trap_no_req", imem_req, 1'b0);
      check1("trap_no_valid", ins_valid, 1'b0);
    end
    check1("trap_held", misalign_trap, 1'b1);
    do_redirect(1'b0, 32'h0000_0040, 32'h0);
    check1("trap_clear", misalign_trap, 1'b0);
    check("trap_exit_addr", imem_addr, 32'h0000_0040);
    #1;
    check1("trap_exit_req", imem_req, 1'b1);
    tick();
    tick();
    check("trap_exit_ins_pc", ins_pc, 32'h0000_0040);
`endif

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
